// File: rtl/data_memory_dump_if.sv
// Processor data-memory bus plus the dump streaming port of the data-memory responder.
// The master side is the processor/bench; the slave side is the memory itself.
interface data_memory_dump_if #(
  parameter int N = 64
);
  logic         memWrite;
  logic         memRead;
  logic [N-1:0] address;
  logic [N-1:0] writeData;
  logic [N-1:0] readData;
  logic         dump;
  logic         busy;
  logic         dump_valid;
  logic         dump_ready;
  logic [N-1:0] dump_addr;
  logic [N-1:0] dump_data;
  logic         dump_done;

  modport master (
    output memWrite, memRead, address, writeData, dump, dump_ready,
    input  readData, busy, dump_valid, dump_addr, dump_data, dump_done
  );

  modport slave (
    input  memWrite, memRead, address, writeData, dump, dump_ready,
    output readData, busy, dump_valid, dump_addr, dump_data, dump_done
  );
endinterface

// File: rtl/data_memory_dump.sv
// Data memory beside processor_arm: zero-latency reads, IDLE-only writes, and a
// valid/ready dump of every word so final memory state can be inspected.
module data_memory_dump #(
  parameter int N  = 64,
  parameter int AW = 5
) (
  input logic              CLOCK_50,
  input logic              reset,
  data_memory_dump_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

  state_t        state, state_next;
  logic [AW-1:0] index, index_next;
  logic          dump_q;
  logic [N-1:0]  mem [0:DEPTH-1];

  logic [AW-1:0] word_idx;
  logic          in_range;
  logic          write_en;
  logic          dump_start;
  logic          unused_addr_bits;

  assign word_idx         = bus.address[AW+2:3];
  assign in_range         = (bus.address[N-1:AW+3] == '0);
  assign unused_addr_bits = ^bus.address[2:0];
  assign write_en         = bus.memWrite && in_range && (state == IDLE);
  assign dump_start       = bus.dump && !dump_q;

  // A read of the word being written this cycle sees the old contents
  assign bus.readData = (bus.memRead && in_range) ? mem[word_idx] : '0;

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[word_idx] <= bus.writeData;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      index  <= '0;
      dump_q <= 1'b0;
    end else begin
      state  <= state_next;
      index  <= index_next;
      dump_q <= bus.dump;
    end
  end

  // Leaving DUMP at the last index keeps the index increment from ever wrapping
  always_comb begin
    state_next     = state;
    index_next     = index;
    bus.busy       = 1'b0;
    bus.dump_valid = 1'b0;
    bus.dump_done  = 1'b0;
    bus.dump_addr  = '0;
    bus.dump_data  = '0;
    unique case (state)
      IDLE: begin
        if (dump_start) begin
          state_next = DUMP;
          index_next = '0;
        end
      end
      DUMP: begin
        bus.busy                = 1'b1;
        bus.dump_valid          = 1'b1;
        bus.dump_addr[AW+2:0]   = {index, 3'b000};
        bus.dump_data           = mem[index];
        if (bus.dump_ready) begin
          if (index == '1) begin
            state_next = DONE;
          end else begin
            index_next = index + 1'b1;
          end
        end
      end
      DONE: begin
        bus.busy      = 1'b1;
        bus.dump_done = 1'b1;
        if (!bus.dump) begin
          state_next = IDLE;
          index_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
        index_next = '0;
      end
    endcase
  end
endmodule

// File: tb/tb_data_memory_dump.sv
// Self-checking bench for data_memory_dump: reference memory model plus a
// scoreboard queue of expected dump beats popped as the DUT transfers them.
module tb_data_memory_dump;
  localparam int N     = 64;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  typedef struct {
    logic [N-1:0] addr;
    logic [N-1:0] data;
  } beat_t;

  logic CLOCK_50;
  logic reset;

  data_memory_dump_if #(.N(N)) bus ();

  data_memory_dump #(.N(N), .AW(AW)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus.slave)
  );

  logic [N-1:0] model [0:DEPTH-1];
  beat_t        sb_q [$];
  int           assert_count = 0;
  int           fail_count   = 0;

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [N-1:0] actual, input logic [N-1:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit wr, input bit rd, input logic [N-1:0] addr, input logic [N-1:0] data);
    bus.memWrite  = wr;
    bus.memRead   = rd;
    bus.address   = addr;
    bus.writeData = data;
  endtask

  // Write while the memory is idle, so the model always takes it when in range
  task automatic writeWord(input logic [N-1:0] addr, input logic [N-1:0] data);
    applyStimulus(1, 0, addr, data);
    @(negedge CLOCK_50);
    if (addr[N-1:AW+3] == '0) model[addr[AW+2:3]] = data;
    applyStimulus(0, 0, '0, '0);
  endtask

  task automatic readCheck(input string tag, input logic [N-1:0] addr, input logic [N-1:0] expected);
    applyStimulus(0, 1, addr, '0);
    #1;
    checkOutput(tag, bus.readData, expected);
  endtask

  task automatic runDump(input bit toggle_ready, input bit hold_dump, input int abort_beat, input bit do_write);
    beat_t b;
    int    popped   = 0;
    bit    finished = 0;
    for (int i = 0; i < DEPTH; i++) begin
      b.addr = N'(i * 8);
      b.data = model[i];
      sb_q.push_back(b);
    end
    bus.dump       = 1'b1;
    bus.dump_ready = 1'b1;
    @(negedge CLOCK_50);
    if (!hold_dump) bus.dump = 1'b0;
    for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
      if (abort_beat >= 0 && popped == abort_beat) begin
        reset = 1'b0;
        #1;
        checkOutput("abort_valid", bus.dump_valid, 0);
        checkOutput("abort_busy", bus.busy, 0);
        checkOutput("abort_addr", bus.dump_addr, 0);
        for (int i = 0; i < DEPTH; i++) begin
          readCheck("abort_mem", N'(i * 8), '0);
          model[i] = '0;
        end
        sb_q.delete();
        finished = 1;
      end else if (sb_q.size() == 0) begin
        checkOutput("dump_done", bus.dump_done, 1);
        checkOutput("done_valid", bus.dump_valid, 0);
        checkOutput("done_busy", bus.busy, 1);
        if (!toggle_ready) checkOutput("dump_cycles", N'(cyc), N'(DEPTH));
        finished = 1;
      end else begin
        if (toggle_ready) bus.dump_ready = (cyc % 2 == 0);
        checkOutput("beat_valid", bus.dump_valid, 1);
        checkOutput("beat_addr", bus.dump_addr, sb_q[0].addr);
        checkOutput("beat_data", bus.dump_data, sb_q[0].data);
        if (do_write && cyc == 4) begin
          applyStimulus(1, 0, 64'h8, 64'h77);
          checkOutput("write_busy", bus.busy, 1);
        end else begin
          applyStimulus(0, 0, '0, '0);
        end
        if (bus.dump_ready) begin
          void'(sb_q.pop_front());
          popped++;
        end
        @(negedge CLOCK_50);
      end
    end
    if (!finished) begin
      checkOutput("dump_timeout", 0, 1);
      sb_q.delete();
    end
    applyStimulus(0, 0, '0, '0);
    bus.dump_ready = 1'b1;
  endtask

  initial begin
    reset          = 1'b0;
    bus.dump       = 1'b0;
    bus.dump_ready = 1'b0;
    applyStimulus(0, 1, 64'h10, '0);
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("rst_read", bus.readData, 0);
    checkOutput("rst_busy", bus.busy, 0);
    checkOutput("rst_valid", bus.dump_valid, 0);
    checkOutput("rst_done", bus.dump_done, 0);
    checkOutput("rst_daddr", bus.dump_addr, 0);
    checkOutput("rst_ddata", bus.dump_data, 0);
    reset = 1'b1;
    @(negedge CLOCK_50);

    applyStimulus(1, 1, 64'h10, 64'hDEADBEEF);
    #1;
    checkOutput("read_old", bus.readData, 0);
    @(negedge CLOCK_50);
    model[2] = 64'hDEADBEEF;
    readCheck("read_new", 64'h10, 64'hDEADBEEF);
    readCheck("read_unaligned", 64'h17, 64'hDEADBEEF);
    readCheck("read_empty", 64'h18, 64'h0);
    applyStimulus(0, 0, 64'h10, '0);
    #1;
    checkOutput("read_disabled", bus.readData, 0);

    applyStimulus(1, 1, 64'h100, 64'h55);
    #1;
    checkOutput("oor_read_same", bus.readData, 0);
    @(negedge CLOCK_50);
    readCheck("oor_read", 64'h100, 64'h0);
    readCheck("oor_word0", 64'h0, 64'h0);
    @(negedge CLOCK_50);

    for (int i = 0; i < DEPTH; i++) writeWord(N'(i * 8), N'(i + 1));
    readCheck("preload_first", 64'h0, 64'h1);
    readCheck("preload_last", 64'hF8, 64'h20);
    @(negedge CLOCK_50);

    runDump(0, 0, -1, 0);
    @(negedge CLOCK_50);
    checkOutput("idle_busy", bus.busy, 0);
    checkOutput("idle_done", bus.dump_done, 0);

    runDump(1, 0, -1, 1);
    @(negedge CLOCK_50);
    readCheck("dropped_write", 64'h8, model[1]);
    @(negedge CLOCK_50);

    runDump(0, 1, -1, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      checkOutput("hold_done", bus.dump_done, 1);
      checkOutput("hold_valid", bus.dump_valid, 0);
    end
    bus.dump = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("release_busy", bus.busy, 0);
    runDump(0, 0, -1, 0);
    @(negedge CLOCK_50);

    runDump(0, 0, 10, 0);
    @(negedge CLOCK_50);
    checkOutput("in_reset_valid", bus.dump_valid, 0);
    reset = 1'b1;
    @(negedge CLOCK_50);
    runDump(0, 0, -1, 0);
    @(negedge CLOCK_50);
    checkOutput("final_busy", bus.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0 expected 1");
    $fatal(1, "[TB] simulation time limit exceeded");
  end
endmodule

// File: doc/data_memory_dump.md
Name: data_memory_dump

Overview:
- Data-memory responder on the far end of the processor's data-memory interface. The processor drives address, write data and write enable; this block stores the data and returns read data.
- On a `dump` request it streams its entire contents out through a valid/ready port, so the bench can check final memory state after a program run.
- Instantiated beside `processor_arm` at top level.

Parameters:
- N, 64, data and address width in bits.
- AW, 5, word-index width; depth = 2**AW words of N bits.

Ports:
- CLOCK_50  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- memWrite  in  1  processor write enable.
- memRead  in  1  processor read enable.
- address  in  N  processor byte address, 8-byte aligned.
- writeData  in  N  processor store data.
- readData  out  N  load data returned to the processor.
- dump  in  1  dump request, level.
- busy  out  1  high while a dump is in progress or complete; processor writes are dropped.
- dump_valid  out  1  dump beat is valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_addr  out  N  byte address of the current beat (index*8).
- dump_data  out  N  contents of the word at the current beat.
- dump_done  out  1  all words have been transferred.

Behaviour:
- Reset (reset=0, asynchronous):
  - all memory words cleared to 0;
  - FSM goes to IDLE, index=0, dump_q=0;
  - readData, dump_valid, dump_addr, dump_data, dump_done and busy all read 0.
  - Reset asserted mid-dump aborts the dump immediately; no further beats are issued.
- Addressing:
  - word index = address[AW+2:3];
  - address[2:0] is ignored;
  - address[N-1:AW+3] != 0 means out of range.
- Write: on a rising edge with memWrite=1, state=IDLE and the address in range, mem[index] <= writeData. Otherwise the write is dropped silently.
- Read (combinational, zero latency):
  - readData = mem[index] when memRead=1 and the address is in range; otherwise 0.
  - A read of the word being written in the same cycle returns the old value; the new value is visible next cycle.
  - Reads are served in every state.
- Dump request detection: dump_q registers dump. A start is dump=1 && dump_q=0, detected in IDLE only. A level held high does not restart the dump.
- FSM, IDLE:
  - busy=0, dump_valid=0, dump_done=0.
  - On start: go to DUMP with index=0.
  - A memWrite in the same cycle as start is still committed.
- FSM, DUMP:
  - busy=1, dump_valid=1, dump_addr={index,3'b000} zero-extended, dump_data=mem[index].
  - Beat transfers on dump_valid && dump_ready.
  - After a transfer: if index==2**AW-1 go to DONE; else index++.
  - dump_ready=0 holds all dump outputs stable.
  - dump deasserting during DUMP does not abort the dump.
- FSM, DONE:
  - busy=1, dump_valid=0, dump_done=1.
  - When dump=0: go to IDLE, index=0.
- Timing: with dump_ready held high, a full dump takes 2**AW cycles from the first beat. dump_done rises the cycle after the last transfer.
- Widths: index is exactly AW bits wide; its increment never wraps, because the FSM leaves DUMP at the maximum index. dump_addr has its upper bits zero-filled.

Test Plan:
- Reset, then memWrite=1, address=0x10, writeData=0xDEADBEEF; next cycle memRead=1, address=0x10 -> readData=0xDEADBEEF. Reading address 0x18 returns 0.
- Write address=0x100 (out of range for AW=5) with data 0x55 -> mem unchanged. A read of 0x100 returns 0, and the read of 0x0 stays 0.
- Pre-load mem[i]=i+1 for all 32 words; pulse dump with dump_ready=1 ->
  - 32 consecutive beats with dump_addr=0x00..0xF8 and dump_data=1..32;
  - dump_done=1 on cycle 33;
  - after dump=0, busy=0 and IDLE.
- During a dump, toggle dump_ready 1/0 every cycle -> each word is emitted exactly once, in order, and outputs are stable while ready=0. Also write 0x77 to address 0x08 during the dump -> mem[1] is unchanged, with busy=1.
- Assert reset=0 at beat 10 of a dump -> on the same edge dump_valid=0, busy=0, and all words read 0. Then raise reset and pulse dump again -> the dump restarts from dump_addr=0.
- Hold dump=1 through DONE for 5 cycles -> dump_done stays 1 and no new beats appear. Drop dump, then raise it again -> a second full dump occurs.
